// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, ALU op codes, FSM state encoding
// and small key-classification helpers used by main_fsb.
package calc_pkg;

   localparam logic [3:0] K_EQUAL = 4'd10;
   localparam logic [3:0] K_AC    = 4'd11;

   // ALU op codes are the operator key codes themselves
   localparam logic [3:0] OP_ADD  = 4'd12;
   localparam logic [3:0] OP_SUB  = 4'd13;
   localparam logic [3:0] OP_MUL  = 4'd14;
   localparam logic [3:0] OP_DIV  = 4'd15;

   localparam logic [2:0] ST_NUM1   = 3'd0;
   localparam logic [2:0] ST_NUM2   = 3'd1;
   localparam logic [2:0] ST_CALC   = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_RESULT = 3'd4;

   function automatic logic key_is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/main_fsb_if.sv
// Keypad / ALU / display bundle of the calculator FSM. master = the FSM,
// slave = the surrounding keypad, external ALU and display.
interface main_fsb_if #(
   parameter int WIDTH = 16
);
   logic             kbEN;
   logic [3:0]       pressedkey;
   logic [WIDTH-1:0] ALUNum1;
   logic [WIDTH-1:0] ALUNum2;
   logic [3:0]       ALUOp;
   logic [WIDTH-1:0] ALUres;
   logic [WIDTH-1:0] Display;

   modport master (
      input  kbEN, pressedkey, ALUres,
      output ALUNum1, ALUNum2, ALUOp, Display
   );

   modport slave (
      output kbEN, pressedkey, ALUres,
      input  ALUNum1, ALUNum2, ALUOp, Display
   );
endinterface

// File: rtl/key_edge_det.sv
// Rising-edge detector for the keypad strobe: one key event per press,
// however long kbEN is held.
module key_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic kb_en,
   output logic key_evt
);
   logic kb_prev_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) kb_prev_reg <= 1'b0;
      else        kb_prev_reg <= kb_en;
   end

   assign key_evt = kb_en & ~kb_prev_reg;
endmodule

// File: rtl/main_fsb.sv
// Four-function calculator control FSM driving an external registered ALU.
// Define CHAIN_RESULT_EN to let an operator key continue from the last result.
module main_fsb
   import calc_pkg::*;
#(
   parameter int         WIDTH      = 16,
   parameter int         MAX_DIGITS = 4,
   parameter logic [3:0] KEY_EQUAL  = K_EQUAL,
   parameter logic [3:0] KEY_AC     = K_AC,
   parameter logic [3:0] KEY_PLUS   = OP_ADD,
   parameter logic [3:0] KEY_MINUS  = OP_SUB,
   parameter logic [3:0] KEY_MULT   = OP_MUL,
   parameter logic [3:0] KEY_DIV    = OP_DIV
) (
   input  logic clk,
   input  logic reset,
   main_fsb_if.master bus
);
   localparam int CW = $clog2(MAX_DIGITS + 1);

   logic             key_evt;
   logic [3:0]       key;
   logic [2:0]       state_reg, state_next;
   logic [WIDTH-1:0] num1_reg, num1_next;
   logic [WIDTH-1:0] num2_reg, num2_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic [WIDTH-1:0] disp_reg, disp_next;
   logic [3:0]       op_reg, op_next;
   logic [CW-1:0]    ndig_reg, ndig_next;

   key_edge_det u_edge (
      .clk     (clk),
      .reset   (reset),
      .kb_en   (bus.kbEN),
      .key_evt (key_evt)
   );

   assign key = bus.pressedkey;

   function automatic logic is_op(input logic [3:0] k);
      return (k == KEY_PLUS) || (k == KEY_MINUS) || (k == KEY_MULT) || (k == KEY_DIV);
   endfunction

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                 input logic [3:0] d);
      return v * WIDTH'(10) + WIDTH'(d);
   endfunction

   always_comb begin
      state_next  = state_reg;
      num1_next   = num1_reg;
      num2_next   = num2_reg;
      result_next = result_reg;
      disp_next   = disp_reg;
      op_next     = op_reg;
      ndig_next   = ndig_reg;

      // ALU sequencing runs regardless of keys; AC below still overrides it
      if (state_reg == ST_CALC) begin
         state_next = ST_WAIT;
      end else if (state_reg == ST_WAIT) begin
         result_next = bus.ALUres;
         disp_next   = bus.ALUres;
         state_next  = ST_RESULT;
      end

      if (key_evt) begin
         if (key == KEY_AC) begin
            num1_next   = '0;
            num2_next   = '0;
            result_next = '0;
            disp_next   = '0;
            op_next     = '0;
            ndig_next   = '0;
            state_next  = ST_NUM1;
         end else begin
            case (state_reg)
               ST_NUM1: begin
                  if (key_is_digit(key)) begin
                     if (ndig_reg < CW'(MAX_DIGITS)) begin
                        num1_next = shift_in(num1_reg, key);
                        disp_next = num1_next;
                        ndig_next = ndig_reg + CW'(1);
                     end
                  end else if (is_op(key)) begin
                     op_next    = key;
                     num2_next  = '0;
                     ndig_next  = '0;
                     state_next = ST_NUM2;
                  end
               end
               ST_NUM2: begin
                  if (key_is_digit(key)) begin
                     if (ndig_reg < CW'(MAX_DIGITS)) begin
                        num2_next = shift_in(num2_reg, key);
                        disp_next = num2_next;
                        ndig_next = ndig_reg + CW'(1);
                     end
                  end else if (is_op(key)) begin
                     op_next = key;
                  end else if (key == KEY_EQUAL) begin
                     state_next = ST_CALC;
                  end
               end
               ST_RESULT: begin
                  if (key_is_digit(key)) begin
                     num1_next  = WIDTH'(key);
                     disp_next  = WIDTH'(key);
                     ndig_next  = CW'(1);
                     state_next = ST_NUM1;
                  end else if (is_op(key)) begin
`ifdef CHAIN_RESULT_EN
                     num1_next  = result_reg;
                     op_next    = key;
                     num2_next  = '0;
                     ndig_next  = '0;
                     state_next = ST_NUM2;
`endif
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= ST_NUM1;
         num1_reg   <= '0;
         num2_reg   <= '0;
         result_reg <= '0;
         disp_reg   <= '0;
         op_reg     <= '0;
         ndig_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         num1_reg   <= num1_next;
         num2_reg   <= num2_next;
         result_reg <= result_next;
         disp_reg   <= disp_next;
         op_reg     <= op_next;
         ndig_reg   <= ndig_next;
      end
   end

   assign bus.ALUNum1 = num1_reg;
   assign bus.ALUNum2 = num2_reg;
   assign bus.ALUOp   = op_reg;
   assign bus.Display = disp_reg;
endmodule

// File: tb/tb_main_fsb.sv
// Bench for main_fsb: directed keypad scenarios plus random key streams
// checked against an operand-level calculator model; includes an ALU model.
module tb_main_fsb;
   import calc_pkg::*;

   localparam int WIDTH = 16;
   localparam int MAXD  = 4;
`ifdef CHAIN_RESULT_EN
   localparam logic [15:0] CHAIN_EXP = 16'd5;
`else
   localparam logic [15:0] CHAIN_EXP = 16'd3;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   main_fsb_if #(.WIDTH(WIDTH)) bus ();

   main_fsb #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_MUL:  return a * b;
         OP_DIV:  return (b == 16'd0) ? 16'hFFFF : a / b;
         default: return 16'd0;
      endcase
   endfunction

   // external ALU: result registered one clock after its operands
   always @(posedge clk) bus.ALUres <= alu_calc(bus.ALUNum1, bus.ALUNum2, bus.ALUOp);

   // calculator model: mode 0 = entering first operand, 1 = second, 2 = showing result
   int m_n1, m_n2, m_res, m_disp, m_op, m_nd, m_mode;

   function automatic void model_clear();
      m_n1 = 0; m_n2 = 0; m_res = 0; m_disp = 0; m_op = 0; m_nd = 0; m_mode = 0;
   endfunction

   function automatic void model_key(input int k);
      if (k == 11) begin
         model_clear();
      end else if (k <= 9) begin
         if (m_mode == 2) begin
            m_n1 = k; m_nd = 1; m_disp = k; m_mode = 0;
         end else if (m_nd < MAXD) begin
            m_nd++;
            if (m_mode == 0) begin m_n1 = (m_n1 * 10 + k) % 65536; m_disp = m_n1; end
            else             begin m_n2 = (m_n2 * 10 + k) % 65536; m_disp = m_n2; end
         end
      end else if (k >= 12) begin
         if (m_mode == 0) begin
            m_op = k; m_n2 = 0; m_nd = 0; m_mode = 1;
         end else if (m_mode == 1) begin
            m_op = k;
         end else begin
`ifdef CHAIN_RESULT_EN
            m_n1 = m_res; m_op = k; m_n2 = 0; m_nd = 0; m_mode = 1;
`endif
         end
      end else if (k == 10 && m_mode == 1) begin
         m_res  = int'(alu_calc(16'(m_n1), 16'(m_n2), 4'(m_op)));
         m_disp = m_res;
         m_mode = 2;
      end
   endfunction

   // caller is at a negedge; returns at a negedge
   task automatic press_raw(input int k, input int hold, input int gap);
      bus.pressedkey = 4'(k);
      bus.kbEN       = 1'b1;
      repeat (hold) @(negedge clk);
      bus.kbEN = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic press(input int k);
      model_key(k);
      press_raw(k, 3, 3);
   endtask

   task automatic test_reset();
      total++; if (bus.Display !== 16'd0) begin bad++; $display("FAIL reset_display got=%0h want=0", bus.Display); end
      total++; if (bus.ALUNum1 !== 16'd0) begin bad++; $display("FAIL reset_num1 got=%0h want=0", bus.ALUNum1); end
      total++; if (bus.ALUNum2 !== 16'd0) begin bad++; $display("FAIL reset_num2 got=%0h want=0", bus.ALUNum2); end
      total++; if (bus.ALUOp !== 4'd0) begin bad++; $display("FAIL reset_op got=%0d want=0", bus.ALUOp); end
      total++; if (dut.state_reg !== ST_NUM1) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_reg, ST_NUM1); end
      $display("reset checked");
   endtask

   task automatic test_add_latency();
      press(11); press(1); press(12); press(1);
      model_key(10);
      bus.pressedkey = K_EQUAL;
      bus.kbEN       = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.Display !== 16'd1) begin bad++; $display("FAIL add_lat0 got=%0h want=1", bus.Display); end
      @(posedge clk); #1;
      total++; if (bus.Display !== 16'd1) begin bad++; $display("FAIL add_lat1 got=%0h want=1", bus.Display); end
      @(posedge clk); #1;
      total++; if (bus.Display !== 16'd2) begin bad++; $display("FAIL add_lat2 got=%0h want=2", bus.Display); end
      total++; if (bus.ALUOp !== 4'd12) begin bad++; $display("FAIL add_op got=%0d want=12", bus.ALUOp); end
      @(negedge clk);
      bus.kbEN = 1'b0;
      repeat (2) @(negedge clk);
      $display("1+1= disp=%0h", bus.Display);
   endtask

   task automatic test_sub();
      press(11); press(1); press(13); press(1); press(10);
      total++; if (bus.Display !== 16'd0) begin bad++; $display("FAIL sub_zero got=%0h want=0", bus.Display); end
      press(11); press(1); press(13); press(2); press(10);
      total++; if (bus.Display !== 16'hFFFF) begin bad++; $display("FAIL sub_wrap got=%0h want=ffff", bus.Display); end
      $display("1-2= disp=%0h", bus.Display);
   endtask

   task automatic test_multi_digit();
      press(11); press(1); press(2);
      total++; if (bus.Display !== 16'd12) begin bad++; $display("FAIL md_entry got=%0d want=12", bus.Display); end
      press(12); press(1); press(10);
      total++; if (bus.Display !== 16'd13) begin bad++; $display("FAIL md_result got=%0d want=13", bus.Display); end
      $display("12+1= disp=%0d", bus.Display);
   endtask

   task automatic test_div_mul();
      press(11); press(1); press(2); press(15); press(2); press(10);
      total++; if (bus.Display !== 16'd6) begin bad++; $display("FAIL div got=%0d want=6", bus.Display); end
      press(11); press(5); press(14); press(3); press(10);
      total++; if (bus.Display !== 16'd15) begin bad++; $display("FAIL mul got=%0d want=15", bus.Display); end
      press(11); press(7); press(15); press(10);
      total++; if (bus.Display !== 16'hFFFF) begin bad++; $display("FAIL div0 got=%0h want=ffff", bus.Display); end
      $display("div/mul disp=%0h", bus.Display);
   endtask

   task automatic test_max_digits_ac();
      press(11); press(1); press(2); press(3); press(4); press(5);
      total++; if (bus.Display !== 16'd1234) begin bad++; $display("FAIL maxdig got=%0d want=1234", bus.Display); end
      press(12);
      press(11);
      total++; if (bus.Display !== 16'd0) begin bad++; $display("FAIL ac_disp got=%0d want=0", bus.Display); end
      total++; if (bus.ALUOp !== 4'd0) begin bad++; $display("FAIL ac_op got=%0d want=0", bus.ALUOp); end
      total++; if (dut.state_reg !== ST_NUM1) begin bad++; $display("FAIL ac_state got=%0d want=%0d", dut.state_reg, ST_NUM1); end
      $display("12345,AC disp=%0d", bus.Display);
   endtask

   task automatic test_chain();
      press(11); press(1); press(12); press(1); press(10); press(12); press(3); press(10);
      total++; if (bus.Display !== CHAIN_EXP) begin bad++; $display("FAIL chain got=%0d want=%0d", bus.Display, CHAIN_EXP); end
      $display("chain disp=%0d", bus.Display);
   endtask

   task automatic test_discard();
      press(11); press(7); press(12); press(8);
      model_key(10);
      press_raw(10, 1, 1);
      press_raw(9, 1, 3);   // lands in WAIT and must be dropped
      total++; if (bus.Display !== 16'd15) begin bad++; $display("FAIL discard_res got=%0d want=15", bus.Display); end
      press(4);
      total++; if (bus.Display !== 16'd4) begin bad++; $display("FAIL discard_next got=%0d want=4", bus.Display); end
      $display("discard disp=%0d", bus.Display);
   endtask

   task automatic test_reset_abort();
      press(11); press(3); press(14); press(4);
      bus.pressedkey = K_EQUAL;
      bus.kbEN       = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk);
      bus.kbEN = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      model_clear();
      total++; if (bus.Display !== 16'd0) begin bad++; $display("FAIL abort_disp got=%0d want=0", bus.Display); end
      total++; if (bus.ALUNum1 !== 16'd0) begin bad++; $display("FAIL abort_num1 got=%0d want=0", bus.ALUNum1); end
      total++; if (dut.state_reg !== ST_NUM1) begin bad++; $display("FAIL abort_state got=%0d want=%0d", dut.state_reg, ST_NUM1); end
      $display("reset abort disp=%0d", bus.Display);
   endtask

   task automatic test_random(input int n);
      int r, k;
      for (int i = 0; i < n; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 55)      k = int'($urandom_range(0, 9));
         else if (r < 75) k = 12 + int'($urandom_range(0, 3));
         else if (r < 93) k = 10;
         else             k = 11;
         model_key(k);
         press_raw(k, int'($urandom_range(1, 4)), int'($urandom_range(2, 3)));
         total++; if (bus.Display !== 16'(m_disp)) begin bad++; $display("FAIL rnd_disp i=%0d got=%0h want=%0h", i, bus.Display, 16'(m_disp)); end
         total++; if (bus.ALUNum1 !== 16'(m_n1)) begin bad++; $display("FAIL rnd_num1 i=%0d got=%0h want=%0h", i, bus.ALUNum1, 16'(m_n1)); end
         total++; if (bus.ALUNum2 !== 16'(m_n2)) begin bad++; $display("FAIL rnd_num2 i=%0d got=%0h want=%0h", i, bus.ALUNum2, 16'(m_n2)); end
         total++; if (bus.ALUOp !== 4'(m_op)) begin bad++; $display("FAIL rnd_op i=%0d got=%0d want=%0d", i, bus.ALUOp, m_op); end
         $display("rnd %0d key=%0d disp=%0h", i, k, bus.Display);
      end
   endtask

   initial begin
      bus.kbEN       = 1'b0;
      bus.pressedkey = 4'd0;
      model_clear();
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      test_add_latency();
      test_sub();
      test_multi_digit();
      test_div_mul();
      test_max_digits_ac();
      test_chain();
      test_discard();
      test_reset_abort();
      test_random(300);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
